avmm_host_rd_arbiter: RTL and testbench
=======================================

Name: avmm_host_rd_arbiter

Overview:
- Shares one AVMM host-read channel (the CCI-P c0 read bridge) between NUM_REQ AVMM read requesters, e.g. DMA descriptor fetch and DMA data read.
- Round-robin arbitration per read command.
- Read responses arrive strictly in order, because MPF read reordering is enabled.
- A tag FIFO records the requester ID and beat count of every issued command; responses are steered back to the owning requester from it.

Parameters:
- NUM_REQ, 2: number of requesters (2..8).
- DATA_WIDTH, 512: readdata width.
- ADDR_WIDTH, 48: byte address width.
- BURST_WIDTH, 3: burstcount width.
- TAG_DEPTH, 64: maximum outstanding commands; power of 2.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- req_read  in  NUM_REQ  per-requester read command.
- req_address  in  NUM_REQ*ADDR_WIDTH  per-requester address, requester i at slice [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_burstcount  in  NUM_REQ*BURST_WIDTH  per-requester burstcount.
- req_waitrequest  out  NUM_REQ  per-requester stall.
- req_readdata  out  DATA_WIDTH  response data, broadcast to all requesters.
- req_readdatavalid  out  NUM_REQ  per-requester response valid.
- host_read  out  1  command to the host read bridge.
- host_address  out  ADDR_WIDTH  command address.
- host_burstcount  out  BURST_WIDTH  command burstcount.
- host_waitrequest  in  1  stall from the bridge.
- host_readdata  in  DATA_WIDTH  response data from the bridge.
- host_readdatavalid  in  1  response valid from the bridge.
- outstanding  out  $clog2(TAG_DEPTH)+1  commands issued but not yet completed.
- rsp_underflow  out  1  sticky error: response received with no outstanding tag.

Behaviour:
- Reset: asynchronous assert, synchronous deassert.
  - In reset: req_readdatavalid=0, rsp_underflow=0, outstanding=0, tag FIFO empty, RR pointer=0, req_readdata=0.
  - Outputs that are combinational from inputs are forced inactive: host_read=0, req_waitrequest all 1.
- Arbitration:
  - Combinational round-robin over req_read.
  - Priority starts at the requester after last_grant; last_grant resets to NUM_REQ-1, so requester 0 has priority first.
  - Grant stays stable while the granted requester holds req_read.
  - host_read = |req_read & ~tag_full. host_address and host_burstcount are muxed from the granted requester.
- Accept: accept = host_read & ~host_waitrequest.
  - On accept: push {id, beats} into the tag FIFO and set last_grant to the granted requester.
  - beats mapping: burstcount 2 -> 2, 4 -> 4, any other value -> 1. This matches the bridge's cl_len encoding.
- req_waitrequest[i] = ~(grant[i] & host_read & ~host_waitrequest).
  - Every non-granted requester sees waitrequest=1.
  - A stalled requester keeps its command held (AVMM rule). The arbiter does not re-arbitrate away from it until accept.
- Tag full: when tag_full, host_read=0 and all waitrequests are 1.
  - This holds even if a pop happens in the same cycle; the full flag is registered.
- Response path: one registered stage, so latency is 1 clk from host_readdatavalid.
  - req_readdata <= host_readdata every cycle.
  - req_readdatavalid[i] <= host_readdatavalid & ~tag_empty & (head.id == i).
  - beat_cnt counts response beats. When host_readdatavalid arrives and beat_cnt == head.beats-1: pop the FIFO and clear beat_cnt. Otherwise beat_cnt increments.
- Underflow: host_readdatavalid with tag_empty sets rsp_underflow sticky until reset. The beat is dropped and no req_readdatavalid is raised.
- Counters and pointers:
  - outstanding = push count minus pop count. A push and a pop in the same cycle leave it unchanged.
  - FIFO pointers wrap modulo TAG_DEPTH.
- Reset mid-operation: all tags are discarded. Stale responses arriving after reset trip rsp_underflow.

Decomposition:
- ccip_avmm_pkg additions:
  - typedef t_avmm_rd_tag {logic [2:0] id; logic [2:0] beats;}
  - constant CCIP_AVMM_RD_TAG_DEPTH = 64.
- Sub-module avmm_rd_tag_fifo:
  - Synchronous FIFO of t_avmm_rd_tag, show-ahead head, registered full/empty.
  - Same clk/reset_n as the arbiter.

Test Plan:
- Single requester: req0 issues 4 reads with burstcount 1,2,4,1 at addresses 0x1000/0x1040/0x1080/0x1100; bridge returns 8 beats -> req_readdatavalid[0] pulses 8 times, each 1 clk after the host beat; outstanding goes 4 -> 0; req_readdatavalid[1] stays 0.
- Fairness: req0 and req1 both hold req_read continuously with burstcount 1 -> host grants alternate 0,1,0,1; 8 accepts give 4 per requester; response steering follows the same order.
- Backpressure: host_waitrequest=1 for 5 cycles while req1 is granted -> host_address stays at req1's address, req0 waitrequest=1 throughout, exactly one accept when the stall ends.
- Full: TAG_DEPTH=4, issue 4 commands with no responses -> host_read=0 and all waitrequests are 1. After one full response burst pops a tag, the next command is accepted.
- Illegal burst: burstcount 3 -> one beat expected. The next response beat belongs to the following tag, so steering stays correct.
- Underflow and reset: host_readdatavalid with outstanding=0 -> rsp_underflow=1, no readdatavalid. Asserting reset_n low mid-burst clears rsp_underflow and outstanding and drops host_read asynchronously.

Source files
------------

// File: rtl/ccip_avmm_pkg.sv
// Shared types and constants for the CCI-P AVMM bridge blocks.
// Holds the read-tag record kept per outstanding host read command.
package ccip_avmm_pkg;

    localparam int CCIP_AVMM_RD_TAG_DEPTH = 64;

    typedef struct packed {
        logic [2:0] id;
        logic [2:0] beats;
    } t_avmm_rd_tag;

    // Response beats produced by the bridge for a given AVMM burstcount (cl_len encoding).
    function automatic logic [2:0] avmm_rd_beats(input logic [31:0] burst);
        case (burst)
            32'd2:   return 3'd2;
            32'd4:   return 3'd4;
            default: return 3'd1;
        endcase
    endfunction

endpackage

// File: rtl/avmm_rd_tag_fifo.sv
// Show-ahead synchronous FIFO of read tags with registered full/empty flags.
// count reports the current occupancy.
module avmm_rd_tag_fifo
    import ccip_avmm_pkg::*;
#(
    parameter int DEPTH = CCIP_AVMM_RD_TAG_DEPTH,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         push,
    input  t_avmm_rd_tag push_tag,
    input  logic         pop,
    output t_avmm_rd_tag head,
    output logic         full,
    output logic         empty,
    output logic [AW:0]  count
);

    t_avmm_rd_tag mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count_q;
    logic [AW:0]   count_next;
    logic          full_q;
    logic          empty_q;
    logic          do_push;
    logic          do_pop;

    assign do_push = push & ~full_q;
    assign do_pop  = pop & ~empty_q;

    always_comb begin
        count_next = count_q;
        case ({do_push, do_pop})
            2'b10:   count_next = count_q + 1'b1;
            2'b01:   count_next = count_q - 1'b1;
            default: count_next = count_q;
        endcase
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count_q <= count_next;
            full_q  <= (count_next == (AW+1)'(DEPTH));
            empty_q <= (count_next == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_tag;
    end

    assign head  = mem[rd_ptr];
    assign full  = full_q;
    assign empty = empty_q;
    assign count = count_q;

endmodule

// File: rtl/avmm_host_rd_arbiter.sv
// Round-robin sharing of one AVMM host-read channel between NUM_REQ requesters.
// In-order responses are steered back to their owner using a tag FIFO.
module avmm_host_rd_arbiter
    import ccip_avmm_pkg::*;
#(
    parameter int NUM_REQ     = 2,
    parameter int DATA_WIDTH  = 512,
    parameter int ADDR_WIDTH  = 48,
    parameter int BURST_WIDTH = 3,
    parameter int TAG_DEPTH   = CCIP_AVMM_RD_TAG_DEPTH,
    localparam int CW = $clog2(TAG_DEPTH) + 1
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [NUM_REQ-1:0]             req_read,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_address,
    input  logic [NUM_REQ*BURST_WIDTH-1:0] req_burstcount,
    output logic [NUM_REQ-1:0]             req_waitrequest,
    output logic [DATA_WIDTH-1:0]          req_readdata,
    output logic [NUM_REQ-1:0]             req_readdatavalid,
    output logic                           host_read,
    output logic [ADDR_WIDTH-1:0]          host_address,
    output logic [BURST_WIDTH-1:0]         host_burstcount,
    input  logic                           host_waitrequest,
    input  logic [DATA_WIDTH-1:0]          host_readdata,
    input  logic                           host_readdatavalid,
    output logic [CW-1:0]                  outstanding,
    output logic                           rsp_underflow
);

    localparam int          IDW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned NREQ = NUM_REQ;

    logic [IDW-1:0]     last_grant;
    logic               lock_valid;
    logic [IDW-1:0]     lock_id;
    logic [IDW-1:0]     grant_id;
    logic [IDW-1:0]     cand;
    logic [NUM_REQ-1:0] grant;
    logic               found;
    logic               accept;

    t_avmm_rd_tag       push_tag;
    t_avmm_rd_tag       tag_head;
    logic               tag_full;
    logic               tag_empty;
    logic               tag_pop;
    logic [2:0]         beat_cnt;
    logic [NUM_REQ-1:0] rdv_next;

    // A stalled command locks the grant so a newly arriving higher-priority
    // requester cannot steal the channel before the held command is accepted.
    always_comb begin
        grant    = '0;
        grant_id = '0;
        cand     = '0;
        found    = 1'b0;
        if (lock_valid && req_read[lock_id]) begin
            grant_id = lock_id;
            found    = 1'b1;
        end else begin
            for (int unsigned k = 1; k <= NREQ; k++) begin
                cand = IDW'((k + 32'(last_grant)) % NREQ);
                if (!found && req_read[cand]) begin
                    grant_id = cand;
                    found    = 1'b1;
                end
            end
        end
        if (found) grant[grant_id] = 1'b1;
    end

    always_comb begin
        host_address    = '0;
        host_burstcount = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                host_address    = req_address[i*ADDR_WIDTH +: ADDR_WIDTH];
                host_burstcount = req_burstcount[i*BURST_WIDTH +: BURST_WIDTH];
            end
        end
    end

    assign host_read       = reset_n & found & ~tag_full;
    assign accept          = host_read & ~host_waitrequest;
    assign req_waitrequest = ~(grant & {NUM_REQ{accept}});

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant <= IDW'(NUM_REQ - 1);
            lock_valid <= 1'b0;
            lock_id    <= '0;
        end else if (accept) begin
            last_grant <= grant_id;
            lock_valid <= 1'b0;
        end else if (host_read) begin
            lock_valid <= 1'b1;
            lock_id    <= grant_id;
        end
    end

    always_comb begin
        push_tag       = '0;
        push_tag.id    = 3'(grant_id);
        push_tag.beats = avmm_rd_beats(32'(host_burstcount));
    end

    avmm_rd_tag_fifo #(
        .DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .push     (accept),
        .push_tag (push_tag),
        .pop      (tag_pop),
        .head     (tag_head),
        .full     (tag_full),
        .empty    (tag_empty),
        .count    (outstanding)
    );

    assign tag_pop = host_readdatavalid & ~tag_empty &
                     (beat_cnt == tag_head.beats - 3'd1);

    always_comb begin
        rdv_next = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            rdv_next[i] = host_readdatavalid & ~tag_empty & (tag_head.id == 3'(i));
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            beat_cnt          <= '0;
            rsp_underflow     <= 1'b0;
            req_readdata      <= '0;
            req_readdatavalid <= '0;
        end else begin
            req_readdata      <= host_readdata;
            req_readdatavalid <= rdv_next;
            if (host_readdatavalid && tag_empty) rsp_underflow <= 1'b1;
            if (host_readdatavalid && !tag_empty) begin
                beat_cnt <= tag_pop ? 3'd0 : beat_cnt + 3'd1;
            end
        end
    end

endmodule

// File: tb/tb_avmm_host_rd_arbiter.sv
// Directed self-checking bench for avmm_host_rd_arbiter (2 requesters, 4-entry tag FIFO).
module tb_avmm_host_rd_arbiter;

    logic         clk;
    logic         reset_n;
    logic [1:0]   req_read;
    logic [95:0]  req_address;
    logic [5:0]   req_burstcount;
    logic [1:0]   req_waitrequest;
    logic [63:0]  req_readdata;
    logic [1:0]   req_readdatavalid;
    logic         host_read;
    logic [47:0]  host_address;
    logic [2:0]   host_burstcount;
    logic         host_waitrequest;
    logic [63:0]  host_readdata;
    logic         host_readdatavalid;
    logic [2:0]   outstanding;
    logic         rsp_underflow;

    int passed = 0;
    int total  = 0;

    avmm_host_rd_arbiter #(
        .NUM_REQ     (2),
        .DATA_WIDTH  (64),
        .ADDR_WIDTH  (48),
        .BURST_WIDTH (3),
        .TAG_DEPTH   (4)
    ) dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .req_read           (req_read),
        .req_address        (req_address),
        .req_burstcount     (req_burstcount),
        .req_waitrequest    (req_waitrequest),
        .req_readdata       (req_readdata),
        .req_readdatavalid  (req_readdatavalid),
        .host_read          (host_read),
        .host_address       (host_address),
        .host_burstcount    (host_burstcount),
        .host_waitrequest   (host_waitrequest),
        .host_readdata      (host_readdata),
        .host_readdatavalid (host_readdatavalid),
        .outstanding        (outstanding),
        .rsp_underflow      (rsp_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int r, input logic [47:0] a, input logic [2:0] bc);
        req_address[r*48 +: 48]  = a;
        req_burstcount[r*3 +: 3] = bc;
        req_read[r]              = 1'b1;
        #1;
        for (int n = 0; n < 20 && req_waitrequest[r]; n++) tick();
        chk("issue_accept", 64'(req_waitrequest[r]), 64'd0);
        chk("issue_addr", 64'(host_address), 64'(a));
        tick();
        req_read[r] = 1'b0;
    endtask

    task automatic beat(input string tag, input logic [1:0] exp_rdv, input logic [63:0] d);
        host_readdatavalid = 1'b1;
        host_readdata      = d;
        tick();
        chk(tag, 64'(req_readdatavalid), 64'(exp_rdv));
        if (exp_rdv != 2'b00) chk({tag, "_data"}, req_readdata, d);
        host_readdatavalid = 1'b0;
    endtask

    initial begin
        reset_n            = 1'b1;
        req_read           = '0;
        req_address        = '0;
        req_burstcount     = '0;
        host_waitrequest   = 1'b0;
        host_readdata      = '0;
        host_readdatavalid = 1'b0;
        #2 reset_n = 1'b0;
        req_read = 2'b01;
        #1;
        chk("rst_host_read", 64'(host_read), 64'd0);
        chk("rst_waitreq", 64'(req_waitrequest), 64'h3);
        chk("rst_outstanding", 64'(outstanding), 64'd0);
        chk("rst_underflow", 64'(rsp_underflow), 64'd0);
        chk("rst_rdv", 64'(req_readdatavalid), 64'd0);
        chk("rst_rdata", req_readdata, 64'd0);
        req_read = 2'b00;
        tick();
        tick();
        reset_n = 1'b1;
        tick();

        // Single requester: bursts 1,2,4,1 fill the 4-entry tag FIFO
        issue(0, 48'h1000, 3'd1);
        issue(0, 48'h1040, 3'd2);
        issue(0, 48'h1080, 3'd4);
        issue(0, 48'h1100, 3'd1);
        chk("single_outstanding4", 64'(outstanding), 64'd4);
        req_address[47:0]  = 48'h2000;
        req_burstcount[2:0] = 3'd1;
        req_read = 2'b01;
        #1;
        chk("full_host_read", 64'(host_read), 64'd0);
        chk("full_waitreq", 64'(req_waitrequest), 64'h3);
        for (int b = 0; b < 9; b++) begin
            if (b == 1) begin
                chk("full_release_read", 64'(host_read), 64'd1);
                chk("full_release_wr", 64'(req_waitrequest), 64'h2);
            end
            beat("single_rdv", 2'b01, 64'hA0 + 64'(b));
            if (b == 0) chk("single_outstanding3", 64'(outstanding), 64'd3);
            if (b == 1) req_read = 2'b00;
        end
        chk("single_outstanding0", 64'(outstanding), 64'd0);
        tick();
        chk("single_rdv_idle", 64'(req_readdatavalid), 64'd0);

        // Fairness: last accept was req0, so req1 leads
        req_address    = {48'h4000, 48'h3000};
        req_burstcount = {3'd1, 3'd1};
        req_read       = 2'b11;
        #1;
        chk("fair_addr0", 64'(host_address), 64'h4000);
        chk("fair_wr0", 64'(req_waitrequest), 64'h1);
        tick();
        chk("fair_addr1", 64'(host_address), 64'h3000);
        chk("fair_wr1", 64'(req_waitrequest), 64'h2);
        tick();
        chk("fair_addr2", 64'(host_address), 64'h4000);
        tick();
        chk("fair_addr3", 64'(host_address), 64'h3000);
        tick();
        chk("fair_full", 64'(host_read), 64'd0);
        chk("fair_outstanding", 64'(outstanding), 64'd4);
        req_read = 2'b00;
        beat("fair_rsp0", 2'b10, 64'hB0);
        beat("fair_rsp1", 2'b01, 64'hB1);
        beat("fair_rsp2", 2'b10, 64'hB2);
        beat("fair_rsp3", 2'b01, 64'hB3);
        chk("fair_drained", 64'(outstanding), 64'd0);

        // Backpressure while req1 holds the grant
        host_waitrequest = 1'b1;
        req_read         = 2'b11;
        #1;
        for (int c = 0; c < 5; c++) begin
            chk("bp_addr", 64'(host_address), 64'h4000);
            chk("bp_waitreq", 64'(req_waitrequest), 64'h3);
            tick();
        end
        chk("bp_no_accept", 64'(outstanding), 64'd0);
        host_waitrequest = 1'b0;
        #1;
        chk("bp_release_wr", 64'(req_waitrequest), 64'h1);
        tick();
        req_read = 2'b00;
        chk("bp_one_accept", 64'(outstanding), 64'd1);
        beat("bp_rsp", 2'b10, 64'hC0);

        // Illegal burstcount 3 counts as one beat
        issue(0, 48'h5000, 3'd3);
        issue(1, 48'h6000, 3'd1);
        beat("illegal_rsp0", 2'b01, 64'hD0);
        beat("illegal_rsp1", 2'b10, 64'hD1);
        chk("illegal_drained", 64'(outstanding), 64'd0);

        // Underflow is sticky
        beat("uf_rdv", 2'b00, 64'hE0);
        chk("uf_set", 64'(rsp_underflow), 64'd1);
        tick();
        chk("uf_sticky", 64'(rsp_underflow), 64'd1);

        // Reset mid-burst
        issue(0, 48'h7000, 3'd4);
        beat("mid_rsp0", 2'b01, 64'hF0);
        beat("mid_rsp1", 2'b01, 64'hF1);
        req_read = 2'b01;
        #1;
        chk("mid_host_read", 64'(host_read), 64'd1);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_host_read", 64'(host_read), 64'd0);
        chk("mid_rst_waitreq", 64'(req_waitrequest), 64'h3);
        chk("mid_rst_underflow", 64'(rsp_underflow), 64'd0);
        chk("mid_rst_outstanding", 64'(outstanding), 64'd0);
        tick();
        reset_n  = 1'b1;
        req_read = 2'b00;
        tick();
        beat("stale_rdv", 2'b00, 64'hF2);
        chk("stale_underflow", 64'(rsp_underflow), 64'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
